// File: rtl/abs_pkg.sv
// rtl/abs_pkg.sv - shared state encoding and brake command codes for the ABS controller
package abs_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        APPLY   = 3'd1,
        RELEASE = 3'd2,
        HOLD    = 3'd3,
        EMERG   = 3'd4
    } abs_state_t;

    localparam logic [1:0] CMD_RELEASE = 2'b00;
    localparam logic [1:0] CMD_HOLD    = 2'b01;
    localparam logic [1:0] CMD_APPLY   = 2'b10;

    // A channel is modulating pressure while it alternates RELEASE/HOLD
    function automatic logic is_modulating(input abs_state_t s);
        return (s == RELEASE) || (s == HOLD);
    endfunction

endpackage

// File: rtl/abs_channel_fsm.sv
// rtl/abs_channel_fsm.sv - one wheel's APPLY/HOLD/RELEASE modulation FSM (fault counter under ABS_FAULT_EN)
import abs_pkg::*;

module abs_channel_fsm #(
    parameter int RELEASE_CYC = 8,
    parameter int HOLD_CYC    = 4,
    parameter int FAULT_CYC   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_demand,
    input  logic       i_obj,
    input  logic       i_slip,
    output logic [1:0] o_cmd,
    output logic       o_active,
    output logic       o_fault
);

    localparam int TMR_MAX = (RELEASE_CYC > HOLD_CYC) ? RELEASE_CYC : HOLD_CYC;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    if (RELEASE_CYC < 1 || HOLD_CYC < 1 || FAULT_CYC < 1) begin : g_param_err
        $error("abs_channel_fsm: RELEASE_CYC, HOLD_CYC and FAULT_CYC must be >= 1");
    end

    abs_state_t       r_state;
    abs_state_t       w_state_base;
    abs_state_t       w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;
    logic             w_fault_nxt;

    // Base transition table; !demand outranks obstacle, which outranks slip and timer expiry
    always_comb begin
        w_state_base = r_state;
        w_timer_nxt  = r_timer;
        case (r_state)
            IDLE: begin
                if (i_obj)
                    w_state_base = EMERG;
                else if (i_demand)
                    w_state_base = APPLY;
            end
            APPLY: begin
                if (!i_demand)
                    w_state_base = IDLE;
                else if (i_obj)
                    w_state_base = EMERG;
                else if (i_slip) begin
                    w_state_base = RELEASE;
                    w_timer_nxt  = TMR_W'(RELEASE_CYC - 1);
                end
            end
            RELEASE: begin
                if (!i_demand)
                    w_state_base = IDLE;
                else if (i_obj)
                    w_state_base = EMERG;
                else if (r_timer == '0) begin
                    w_state_base = HOLD;
                    w_timer_nxt  = TMR_W'(HOLD_CYC - 1);
                end else
                    w_timer_nxt = r_timer - 1'b1;
            end
            HOLD: begin
                if (!i_demand)
                    w_state_base = IDLE;
                else if (i_obj)
                    w_state_base = EMERG;
                else if (r_timer == '0) begin
                    if (i_slip) begin
                        w_state_base = RELEASE;
                        w_timer_nxt  = TMR_W'(RELEASE_CYC - 1);
                    end else
                        w_state_base = APPLY;
                end else
                    w_timer_nxt = r_timer - 1'b1;
            end
            EMERG: begin
                if (!i_demand)
                    w_state_base = IDLE;
            end
            default: begin
                w_state_base = IDLE;
                w_timer_nxt  = '0;
            end
        endcase
    end

`ifdef ABS_FAULT_EN
    localparam int FCNT_W = $clog2(FAULT_CYC + 1);

    logic [FCNT_W-1:0] r_fcnt;
    logic [FCNT_W-1:0] w_fcnt_inc;
    logic              r_fault;
    logic              w_fault_hit;

    assign w_fcnt_inc  = r_fcnt + 1'b1;
    assign w_fault_hit = is_modulating(r_state) && (w_fcnt_inc == FCNT_W'(FAULT_CYC));
    assign w_fault_nxt = r_fault | w_fault_hit;
    assign o_fault     = r_fault;

    // Count consecutive modulating cycles; the fault flag is sticky until reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fcnt  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_fcnt  <= is_modulating(r_state) ? w_fcnt_inc : '0;
            r_fault <= w_fault_nxt;
        end
    end
`else
    assign w_fault_nxt = 1'b0;
    assign o_fault     = 1'b0;
`endif

    // A faulted channel falls back to conventional braking: never enters RELEASE/HOLD
    always_comb begin
        w_state_nxt = w_state_base;
        if (w_fault_nxt && is_modulating(w_state_base))
            w_state_nxt = APPLY;
    end

    // State and modulation timer; reset aborts any modulation at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_timer <= w_timer_nxt;
        end
    end

    // Moore output decode from the registered state
    always_comb begin
        o_cmd = CMD_RELEASE;
        case (r_state)
            APPLY:   o_cmd = CMD_APPLY;
            EMERG:   o_cmd = CMD_APPLY;
            HOLD:    o_cmd = CMD_HOLD;
            default: o_cmd = CMD_RELEASE;
        endcase
    end

    assign o_active = is_modulating(r_state);

endmodule

// File: rtl/abs_multi_channel_ctrl.sv
// rtl/abs_multi_channel_ctrl.sv - multi-wheel ABS controller top (optional fault supervision: ABS_FAULT_EN)
import abs_pkg::*;

module abs_multi_channel_ctrl #(
    parameter int NUM_CH      = 4,
    parameter int SPD_W       = 8,
    parameter int LOCK_THRESH = 20,
    parameter int SLIP_DELTA  = 16,
    parameter int RELEASE_CYC = 8,
    parameter int HOLD_CYC    = 4,
    parameter int FAULT_CYC   = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_brake_pedal,
    input  logic                    i_object_detected,
    input  logic [SPD_W-1:0]        i_vehicle_speed,
    input  logic [NUM_CH*SPD_W-1:0] i_wheel_speed,
    output logic [2*NUM_CH-1:0]     o_brake_cmd,
    output logic [NUM_CH-1:0]       o_abs_active,
    output logic [NUM_CH-1:0]       o_abs_fault
);

    localparam int SW1 = SPD_W + 1;

    logic           w_demand;
    logic           w_lock_ok;
    logic [SW1-1:0] w_vehicle_ext;

    assign w_demand      = i_brake_pedal | i_object_detected;
    assign w_lock_ok     = ({1'b0, i_vehicle_speed} >= SW1'(LOCK_THRESH));
    assign w_vehicle_ext = {1'b0, i_vehicle_speed};

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [SPD_W-1:0] w_wheel;
        logic             w_slip;

        assign w_wheel = i_wheel_speed[g*SPD_W +: SPD_W];
        // Extra bit keeps wheel + delta from wrapping
        assign w_slip  = w_lock_ok && (({1'b0, w_wheel} + SW1'(SLIP_DELTA)) < w_vehicle_ext);

        abs_channel_fsm #(
            .RELEASE_CYC (RELEASE_CYC),
            .HOLD_CYC    (HOLD_CYC),
            .FAULT_CYC   (FAULT_CYC)
        ) u_fsm (
            .clk      (clk),
            .rst      (rst),
            .i_demand (w_demand),
            .i_obj    (i_object_detected),
            .i_slip   (w_slip),
            .o_cmd    (o_brake_cmd[2*g +: 2]),
            .o_active (o_abs_active[g]),
            .o_fault  (o_abs_fault[g])
        );
    end

endmodule
